// File: rtl/srl_delay_ctrl_pkg.sv
// Shared types and sizing for the SRL-based delay controller.
package srl_ctrl_pkg;

    // Default maximum depth and the matching tap-address width.
    localparam int MAX_DEPTH_DEF = 32;
    localparam int DEPTH_W       = $clog2(MAX_DEPTH_DEF);

    // Controller states.
    //   IDLE  : no depth configured yet
    //   FILL  : accepting input until depth entries are stored
    //   RUN   : lock-step accept/emit, line holds exactly depth entries
    //   DRAIN : push the stored entries out without accepting new input
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/srl_delay_line.sv
// Reset-free addressable shift register: one shift per enabled cycle,
// newest sample at index 0, combinational read at the tap address.
module srl_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     sh_en,
    input  logic [WIDTH-1:0]         din,
    input  logic [$clog2(DEPTH)-1:0] tap,
    output logic [WIDTH-1:0]         dout
);

    // No reset and a single shift enable so the storage maps onto SRL cells.
    logic [WIDTH-1:0] mem [DEPTH];

    // Shift the whole line by one position when enabled.
    always_ff @(posedge clk) begin
        if (sh_en) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign dout = mem[tap];

endmodule

// File: rtl/srl_delay_ctrl.sv
// Delay-line controller: programmable delay of 1..MAX_DEPTH accepted
// transfers with fill, lock-step run and drain phases around an SRL line.
module srl_delay_ctrl
    import srl_ctrl_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_DEPTH = MAX_DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_load,
    input  logic [$clog2(MAX_DEPTH)-1:0] cfg_depth,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(MAX_DEPTH):0]   fill_cnt,
    output logic                         busy
);

    localparam int AW = $clog2(MAX_DEPTH);
    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

    state_t          state;
    logic [AW:0]     depth;      // configured depth, 1..MAX_DEPTH
    logic [AW-1:0]   tap;        // depth-1, kept separately to avoid a subtractor on the read path
    logic [AW:0]     align;      // junk shifts still needed to bring the oldest entry to the tap
    logic [AW:0]     remaining;  // entries still to be emitted while draining
    logic            sh_en;
    logic [AW:0]     fill_inc;   // fill count after this cycle's shift, if any

    assign fill_inc = fill_cnt + {{AW{1'b0}}, sh_en};

    // Handshake, shift enable and status decode from the current state.
    always_comb begin
        sh_en     = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state != IDLE);
        case (state)
            FILL: begin
                in_ready = 1'b1;
                sh_en    = in_valid & ~cfg_load;
            end
            RUN: begin
                in_ready  = out_ready;
                out_valid = 1'b1;
                sh_en     = in_valid & out_ready & ~cfg_load;
            end
            DRAIN: begin
                if (align != '0) begin
                    sh_en = ~cfg_load;
                end else begin
                    out_valid = 1'b1;
                    sh_en     = out_ready & ~cfg_load;
                end
            end
            default: begin
                sh_en = 1'b0;
            end
        endcase
    end

    // Control FSM: configuration takes priority, then flush, then normal progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            depth     <= ONE;
            tap       <= '0;
            fill_cnt  <= '0;
            align     <= '0;
            remaining <= '0;
        end else if (cfg_load) begin
            state     <= FILL;
            depth     <= {1'b0, cfg_depth} + ONE;
            tap       <= cfg_depth;
            fill_cnt  <= '0;
            align     <= '0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= IDLE;
                end
                FILL: begin
                    // An input accepted in the flush cycle is counted as stored.
                    if (flush && (fill_inc != '0)) begin
                        state     <= DRAIN;
                        fill_cnt  <= fill_inc;
                        align     <= depth - fill_inc;
                        remaining <= fill_inc;
                    end else begin
                        fill_cnt <= fill_inc;
                        if (fill_inc == depth) begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (flush) begin
                        state     <= DRAIN;
                        align     <= '0;
                        remaining <= depth;
                    end
                end
                DRAIN: begin
                    if (align != '0) begin
                        align <= align - ONE;
                    end else if (sh_en) begin
                        if (remaining == ONE) begin
                            state     <= FILL;
                            fill_cnt  <= '0;
                            remaining <= '0;
                        end else begin
                            remaining <= remaining - ONE;
                            if (fill_cnt != '0) begin
                                fill_cnt <= fill_cnt - ONE;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    srl_delay_line #(
        .WIDTH (WIDTH),
        .DEPTH (MAX_DEPTH)
    ) u_line (
        .clk   (clk),
        .sh_en (sh_en),
        .din   (in_data),
        .tap   (tap),
        .dout  (out_data)
    );

endmodule

// File: tb/tb_srl_delay_ctrl.sv
// Directed bench for srl_delay_ctrl with hand-computed expectations.
module tb_srl_delay_ctrl;

    localparam int WIDTH     = 8;
    localparam int MAX_DEPTH = 32;
    localparam int AW        = $clog2(MAX_DEPTH);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfg_load;
    logic [AW-1:0]    cfg_depth;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [AW:0]      fill_cnt;
    logic             busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    srl_delay_ctrl #(
        .WIDTH     (WIDTH),
        .MAX_DEPTH (MAX_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_load  (cfg_load),
        .cfg_depth (cfg_depth),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .fill_cnt  (fill_cnt),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; cfg_load = 1'b0; cfg_depth = '0; flush = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fill", fill_cnt, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // IDLE ignores flush and input
        flush = 1'b1; in_valid = 1'b1; in_data = 8'h99;
        #1;
        chk("idle_in_ready", in_ready, 0);
        chk("idle_out_valid", out_valid, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_fill", fill_cnt, 0);

        // depth 4, inputs 1..6 with out_ready=1
        cfg_load = 1'b1; cfg_depth = 5'd3;
        tick();
        cfg_load = 1'b0;
        #1;
        chk("cfg4_busy", busy, 1);
        chk("cfg4_in_ready", in_ready, 1);
        chk("cfg4_out_valid", out_valid, 0);
        chk("cfg4_fill", fill_cnt, 0);
        out_ready = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            #1;
            if (i <= 4) begin
                chk("d4_fill_ov", out_valid, 0);
                chk("d4_fill_cnt", fill_cnt, 32'(i - 1));
            end
            tick();
            if (i >= 4) begin
                chk("d4_run_ov", out_valid, 1);
                chk("d4_run_data", out_data, 32'(i - 3));
                chk("d4_run_fill", fill_cnt, 4);
            end
        end
        in_valid = 1'b0;

        // Backpressure in RUN: no accept, no shift
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_data", out_data, 3);
            tick();
        end
        chk("bp_fill", fill_cnt, 4);
        chk("bp_data_after", out_data, 3);
        in_data = 8'h07; out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        tick();
        chk("bp_release_data", out_data, 4);
        in_valid = 1'b0;

        // cfg_load + flush + input in RUN: reconfigure, input dropped
        cfg_load = 1'b1; flush = 1'b1; cfg_depth = 5'd7; in_valid = 1'b1; in_data = 8'h55;
        tick();
        cfg_load = 1'b0; flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("cfgfl_fill", fill_cnt, 0);
        chk("cfgfl_out_valid", out_valid, 0);
        chk("cfgfl_in_ready", in_ready, 1);
        chk("cfgfl_busy", busy, 1);

        // depth 8, three entries, then flush: 5 align cycles then 11,22,33
        in_valid = 1'b1; in_data = 8'h11; tick();
        in_data = 8'h22; tick();
        in_data = 8'h33; tick();
        in_valid = 1'b0;
        #1;
        chk("pre_flush_fill", fill_cnt, 3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("align_out_valid", out_valid, 0);
            chk("align_in_ready", in_ready, 0);
            chk("align_fill", fill_cnt, 3);
            tick();
        end
        chk("drain_ov0", out_valid, 1);
        chk("drain_d0", out_data, 8'h11);
        tick();
        chk("drain_d1", out_data, 8'h22);
        chk("drain_f1", fill_cnt, 2);
        tick();
        chk("drain_d2", out_data, 8'h33);
        chk("drain_f2", fill_cnt, 1);
        tick();
        chk("drain_end_ov", out_valid, 0);
        chk("drain_end_fill", fill_cnt, 0);
        chk("drain_end_ready", in_ready, 1);
        chk("drain_end_busy", busy, 1);

        // Stall in DRAIN, then reset mid-drain
        in_valid = 1'b1; in_data = 8'h44; tick();
        in_data = 8'h66; tick();
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (6) tick();
        out_ready = 1'b0;
        #1;
        chk("dstall_ov", out_valid, 1);
        chk("dstall_d", out_data, 8'h44);
        tick();
        tick();
        chk("dstall_d_held", out_data, 8'h44);
        chk("dstall_fill", fill_cnt, 2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstd_out_valid", out_valid, 0);
        chk("rstd_busy", busy, 0);
        chk("rstd_in_ready", in_ready, 0);
        chk("rstd_fill", fill_cnt, 0);
        rst_n = 1'b1;
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h77; flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_ready", in_ready, 0);
            chk("post_rst_busy", busy, 0);
            chk("post_rst_ov", out_valid, 0);
            tick();
        end
        in_valid = 1'b0;

        // depth 32: flush with nothing stored is ignored, then 40 accepts
        cfg_load = 1'b1; cfg_depth = 5'd31;
        tick();
        cfg_load = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("d32_flush0_busy", busy, 1);
        chk("d32_flush0_ready", in_ready, 1);
        chk("d32_flush0_ov", out_valid, 0);
        chk("d32_flush0_fill", fill_cnt, 0);
        for (int k = 1; k <= 40; k++) begin
            in_valid = 1'b1; in_data = 8'(k);
            #1;
            if (k <= 32) begin
                chk("d32_fill_ov", out_valid, 0);
            end
            tick();
            if (k >= 32) begin
                chk("d32_data", out_data, 32'(k - 31));
                chk("d32_fill", fill_cnt, 32);
                chk("d32_ov", out_valid, 1);
            end
        end
        in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/srl_delay_ctrl.md
SRL_DELAY_CTRL -- requirements
Module: srl_delay_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: data width in bits.
REQ-002 The block SHALL have parameter MAX_DEPTH, default 32: maximum delay depth in entries (power of two, 2..32).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port cfg_load, input, 1 bit: single-cycle pulse that latches cfg_depth.
REQ-006 The block SHALL have port cfg_depth, input, log2(MAX_DEPTH) bits: requested depth minus 1 (0 = 1 entry, 31 = 32 entries).
REQ-007 The block SHALL have port flush, input, 1 bit: single-cycle pulse that requests a drain of stored entries.
REQ-008 The block SHALL have port in_valid, input, 1 bit: input handshake.
REQ-009 The block SHALL have port in_ready, output, 1 bit: input handshake.
REQ-010 The block SHALL have port in_data, input, WIDTH bits: input data.
REQ-011 The block SHALL have port out_valid, output, 1 bit: output handshake.
REQ-012 The block SHALL have port out_ready, input, 1 bit: output handshake.
REQ-013 The block SHALL have port out_data, output, WIDTH bits: data at tap depth-1.
REQ-014 The block SHALL have port fill_cnt, output, log2(MAX_DEPTH)+1 bits: count of valid stored entries.
REQ-015 The block SHALL have port busy, output, 1 bit: asserted whenever state != IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, FILL, RUN and DRAIN.
- IDLE: no depth configured; in_ready=0, out_valid=0.
REQ-017 The block SHALL perform one shift of the delay line per cycle with shift enable sh_en, and nothing else shall modify stored data.
REQ-018 In FILL the block SHALL hold in_ready=1 and out_valid=0, set sh_en = in_valid, increment fill_cnt per shift, and enter RUN when fill_cnt reaches depth.
REQ-019 In RUN the block SHALL hold out_valid=1, set in_ready = out_ready, and set sh_en = in_valid & out_ready (lock-step consume/accept); fill_cnt stays equal to depth.
REQ-020 out_data SHALL equal the input accepted exactly depth accepted transfers earlier (tap index depth-1, combinational read).
REQ-021 cfg_load in any state SHALL latch depth = cfg_depth+1, clear fill_cnt, discard content and enter FILL on the next cycle.
REQ-022 Flush in RUN SHALL enter DRAIN with remaining=depth.
REQ-023 Flush in FILL with fill_cnt>0 SHALL enter DRAIN with align=depth-fill_cnt and remaining=fill_cnt.
REQ-024 Flush in FILL with fill_cnt=0, and flush in IDLE or DRAIN, SHALL have no effect.
REQ-025 In DRAIN the block SHALL hold in_ready=0; while align>0 it SHALL set sh_en=1 and out_valid=0 and decrement align each cycle.
REQ-026 In DRAIN with align=0 the block SHALL hold out_valid=1, set sh_en = out_ready, and decrement remaining and fill_cnt per shift.
REQ-027 When remaining reaches 0 the block SHALL enter FILL with fill_cnt=0.
REQ-028 If cfg_load and flush are asserted in the same cycle, cfg_load SHALL take priority.
REQ-029 If cfg_load and an input transfer occur in the same cycle, the input SHALL be discarded (no shift).
REQ-030 fill_cnt SHALL never exceed depth and SHALL never wrap below 0.

Reset
REQ-031 rst_n low SHALL asynchronously force state=IDLE, depth=1, fill_cnt=0, align=0, remaining=0, in_ready=0, out_valid=0 and busy=0.
REQ-032 Delay-line data storage SHALL have no reset (required for shift-register primitive inference); out_data is undefined until the first RUN.
REQ-033 Reset asserted mid-FILL, mid-RUN or mid-DRAIN SHALL behave identically to power-on reset; cfg_load is required to leave IDLE.

Structure
REQ-034 Package srl_ctrl_pkg SHALL hold the state enum and the DEPTH_W = log2(MAX_DEPTH) constant.
REQ-035 Sub-module srl_delay_line SHALL hold the reset-free storage with sh_en, data in, and a tap address input (storage plus tap mux only).
REQ-036 Synthesis of srl_delay_line SHALL map to WIDTH 32-deep addressable shift-register cells with zero data-path flip-flops.

Verification
REQ-037 Scenario: cfg_depth=3 followed by inputs 0x01..0x06 with out_ready=1 -> out_valid rises after the 4th accept and out_data=0x01, with 0x02 following on the 5th accept.
REQ-038 Scenario: RUN at depth 4 with out_ready=0 and in_valid=1 for 5 cycles -> in_ready=0, no shift, and out_data held.
REQ-039 Scenario: depth 8 with fill_cnt=3 followed by flush -> 5 cycles with out_valid=0, then the three oldest entries output in order, then FILL with fill_cnt=0.
REQ-040 Scenario: cfg_load and flush asserted in the same cycle during RUN -> FILL with fill_cnt=0 and the new depth.
REQ-041 Scenario: rst_n dropped mid-DRAIN -> immediate IDLE with out_valid=0; in_ready stays 0 until cfg_load.
REQ-042 Scenario: cfg_depth=31 with 40 accepts -> the output sequence equals the input sequence delayed by 32 transfers, and fill_cnt=32.
